// File: rtl/norm_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : norm_mult_pkg
// Description : Shared overflow-mode encodings and pipeline latency for
//               norm_mult_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package norm_mult_pkg;

    localparam logic [1:0] OFLOW_WRAP = 2'b00;
    localparam logic [1:0] OFLOW_KILL = 2'b01;
    localparam logic [1:0] OFLOW_SAT  = 2'b10;

    localparam int NORM_MULT_LAT = 5;

endpackage : norm_mult_pkg
`default_nettype wire

// File: rtl/norm_mult_pipe_scale_clip.sv
`default_nettype none
// ============================================================================
// Module      : scale_clip
// Description : Combinational slice of a signed product with overflow detect
//               and wrap/kill/saturate handling. NORM_MULT_ROUND_EN selects
//               round-half-up instead of truncation.
// Revision    : 1.0 - initial release
// ============================================================================
module scale_clip
    import norm_mult_pkg::*;
#(
    parameter int IN_W  = 30,
    parameter int OUT_W = 16,
    parameter int SHIFT = 6
) (
    input  logic [IN_W-1:0]  din,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] dout,
    output logic             oflow
);

    // Extension covers every slice position, so the top field always exists.
    localparam int c_ext_w   = IN_W + OUT_W + 1;
    localparam int c_top_lsb = SHIFT + OUT_W - 1;

`ifdef NORM_MULT_ROUND_EN
    localparam logic [c_ext_w-1:0] c_rnd =
        (SHIFT > 0) ? (c_ext_w'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`else
    localparam logic [c_ext_w-1:0] c_rnd = '0;
`endif

    localparam logic [OUT_W-1:0] c_pos_max = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] c_neg_max = {1'b1, {(OUT_W-1){1'b0}}};

    logic [c_ext_w-1:0]           w_ext;
    logic [c_ext_w-c_top_lsb-1:0] w_top;
    logic [OUT_W-1:0]             w_slice;
    logic                         w_neg;
    logic                         unused_ext;

    assign w_ext      = {{(OUT_W+1){din[IN_W-1]}}, din} + c_rnd;
    assign w_top      = w_ext[c_ext_w-1:c_top_lsb];
    assign w_slice    = w_ext[c_top_lsb:SHIFT];
    assign w_neg      = w_ext[c_ext_w-1];
    assign oflow      = !((&w_top) || (~|w_top));
    assign unused_ext = ^w_ext;

    always_comb begin
        dout = w_slice;
        if (oflow) begin
            case (mode)
                OFLOW_WRAP: dout = w_slice;
                OFLOW_SAT:  dout = w_neg ? c_neg_max : c_pos_max;
                default:    dout = '0;
            endcase
        end
    end

endmodule : scale_clip
`default_nettype wire

// File: rtl/norm_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : norm_mult_pipe
// Description : 5-stage signed gain x normalisation multiplier with per-stage
//               overflow handling, sticky flags and a saturating event counter.
//               Optional macro: NORM_MULT_ROUND_EN (round-half-up slicing).
// Revision    : 1.0 - initial release
// ============================================================================
module norm_mult_pipe
    import norm_mult_pkg::*;
#(
    parameter int DIN_W      = 16,
    parameter int GAIN_W     = 14,
    parameter int LUT_W      = 18,
    parameter int DOUT_W     = 16,
    parameter int GAIN_SHIFT = 6,
    parameter int NORM_SHIFT = 15,
    parameter int OCNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic [DIN_W-1:0]  din,
    input  logic [GAIN_W-1:0] gain,
    input  logic [LUT_W-1:0]  lut_val,
    input  logic              use_diode,
    input  logic [1:0]        oflow_mode,
    input  logic              clr_oflow,
    output logic              dout_valid,
    output logic [DOUT_W-1:0] dout,
    output logic              gain_oflow,
    output logic              norm_oflow,
    output logic              oflow_pulse,
    output logic [OCNT_W-1:0] oflow_count
);

    localparam int c_gprod_w = DIN_W + GAIN_W;
    localparam int c_nprod_w = DIN_W + LUT_W;

    // Quasi-static controls cross in through plain flop chains kept out of SRLs/DSPs.
    (* shreg_extract = "no", use_dsp = "no" *) logic [GAIN_W-1:0] r_gain_m;
    (* shreg_extract = "no", use_dsp = "no" *) logic [GAIN_W-1:0] r_gain_q;
    (* shreg_extract = "no", use_dsp = "no" *) logic [LUT_W-1:0]  r_lut_m;
    (* shreg_extract = "no", use_dsp = "no" *) logic [LUT_W-1:0]  r_lut_q;

    logic                        r1_valid;
    logic [DIN_W-1:0]            r1_din;
    logic                        r2_valid;
    logic signed [c_gprod_w-1:0] r2_gprod;
    logic                        r3_valid;
    logic [DIN_W-1:0]            r3_gout;
    logic                        r3_gof;
    logic                        r4_valid;
    logic signed [c_nprod_w-1:0] r4_nprod;
    logic [DIN_W-1:0]            r4_gout;
    logic                        r4_gof;

    logic signed [c_gprod_w-1:0] w_gprod;
    logic signed [c_nprod_w-1:0] w_nprod;
    logic [DIN_W-1:0]            w_gout;
    logic                        w_gof;
    logic [DOUT_W-1:0]           w_dio_out;
    logic                        w_dio_of;
    logic [DOUT_W-1:0]           w_byp_out;
    logic                        w_byp_of;
    logic [DOUT_W-1:0]           w_nout;
    logic                        w_nof;
    logic                        w_gev;
    logic                        w_nev;
    logic                        w_ev;
    logic                        w_cnt_max;

    assign w_gprod = $signed(r1_din) * $signed(r_gain_q);
    assign w_nprod = $signed(r3_gout) * $signed(r_lut_q);

    scale_clip #(
        .IN_W  (c_gprod_w),
        .OUT_W (DIN_W),
        .SHIFT (GAIN_SHIFT)
    ) u_gain_clip (
        .din   (r2_gprod),
        .mode  (oflow_mode),
        .dout  (w_gout),
        .oflow (w_gof)
    );

    scale_clip #(
        .IN_W  (c_nprod_w),
        .OUT_W (DOUT_W),
        .SHIFT (NORM_SHIFT)
    ) u_norm_clip (
        .din   (r4_nprod),
        .mode  (oflow_mode),
        .dout  (w_dio_out),
        .oflow (w_dio_of)
    );

    // Bypass path: plain resize of the gain-stage result to the output width.
    scale_clip #(
        .IN_W  (DIN_W),
        .OUT_W (DOUT_W),
        .SHIFT (0)
    ) u_bypass_clip (
        .din   (r4_gout),
        .mode  (oflow_mode),
        .dout  (w_byp_out),
        .oflow (w_byp_of)
    );

    assign w_nout    = use_diode ? w_dio_out : w_byp_out;
    assign w_nof     = use_diode ? w_dio_of  : w_byp_of;
    assign w_gev     = r4_valid & r4_gof;
    assign w_nev     = r4_valid & w_nof;
    assign w_ev      = w_gev | w_nev;
    assign w_cnt_max = &oflow_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gain_m <= '0;
            r_gain_q <= '0;
            r_lut_m  <= '0;
            r_lut_q  <= '0;
        end else begin
            r_gain_m <= gain;
            r_gain_q <= r_gain_m;
            r_lut_m  <= lut_val;
            r_lut_q  <= r_lut_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_din   <= '0;
            r2_valid <= 1'b0;
            r2_gprod <= '0;
            r3_valid <= 1'b0;
            r3_gout  <= '0;
            r3_gof   <= 1'b0;
            r4_valid <= 1'b0;
            r4_nprod <= '0;
            r4_gout  <= '0;
            r4_gof   <= 1'b0;
        end else begin
            r1_valid <= din_valid;
            r1_din   <= din;
            r2_valid <= r1_valid;
            r2_gprod <= w_gprod;
            r3_valid <= r2_valid;
            r3_gout  <= w_gout;
            r3_gof   <= r2_valid & w_gof;
            r4_valid <= r3_valid;
            r4_nprod <= w_nprod;
            r4_gout  <= r3_gout;
            r4_gof   <= r3_gof;
        end
    end

    // Flags and counter update on the same edge that presents the sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_valid  <= 1'b0;
            dout        <= '0;
            oflow_pulse <= 1'b0;
            gain_oflow  <= 1'b0;
            norm_oflow  <= 1'b0;
            oflow_count <= '0;
        end else begin
            dout_valid  <= r4_valid;
            dout        <= w_nout;
            oflow_pulse <= w_ev;
            gain_oflow  <= w_gev | (gain_oflow & ~clr_oflow);
            norm_oflow  <= w_nev | (norm_oflow & ~clr_oflow);
            if (clr_oflow) begin
                oflow_count <= OCNT_W'(w_ev);
            end else if (w_ev && !w_cnt_max) begin
                oflow_count <= oflow_count + OCNT_W'(1);
            end
        end
    end

endmodule : norm_mult_pipe
`default_nettype wire

// File: tb/tb_norm_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_norm_mult_pipe
// Description : Directed self-checking bench for norm_mult_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_norm_mult_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        din_valid;
    logic [15:0] din;
    logic [13:0] gain;
    logic [17:0] lut_val;
    logic        use_diode;
    logic [1:0]  oflow_mode;
    logic        clr_oflow;

    logic        dout_valid;
    logic [15:0] dout;
    logic        gain_oflow;
    logic        norm_oflow;
    logic        oflow_pulse;
    logic [15:0] oflow_count;

    logic        sat_dout_valid;
    logic [15:0] sat_dout;
    logic        sat_gain_oflow;
    logic        sat_norm_oflow;
    logic        sat_oflow_pulse;
    logic [3:0]  sat_oflow_count;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] pat = 8'b1011_0101;

    always #5 clk = ~clk;

    norm_mult_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .din         (din),
        .gain        (gain),
        .lut_val     (lut_val),
        .use_diode   (use_diode),
        .oflow_mode  (oflow_mode),
        .clr_oflow   (clr_oflow),
        .dout_valid  (dout_valid),
        .dout        (dout),
        .gain_oflow  (gain_oflow),
        .norm_oflow  (norm_oflow),
        .oflow_pulse (oflow_pulse),
        .oflow_count (oflow_count)
    );

    norm_mult_pipe #(.OCNT_W(4)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .din         (din),
        .gain        (gain),
        .lut_val     (lut_val),
        .use_diode   (use_diode),
        .oflow_mode  (oflow_mode),
        .clr_oflow   (clr_oflow),
        .dout_valid  (sat_dout_valid),
        .dout        (sat_dout),
        .gain_oflow  (sat_gain_oflow),
        .norm_oflow  (sat_norm_oflow),
        .oflow_pulse (sat_oflow_pulse),
        .oflow_count (sat_oflow_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] d);
        @(negedge clk);
        din       = d;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    // One sample in, then stop at the negedge where it must appear.
    task automatic run(input logic [15:0] d);
        send(d);
        repeat (3) @(negedge clk);
        chk("not_early", 32'(dout_valid), 32'd0);
        @(negedge clk);
        chk("valid_at_lat", 32'(dout_valid), 32'd1);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        din_valid  = 1'b0;
        din        = '0;
        gain       = '0;
        lut_val    = '0;
        use_diode  = 1'b0;
        oflow_mode = 2'b00;
        clr_oflow  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout",  32'(dout),       32'd0);
        chk("rst_gof",   32'(gain_oflow), 32'd0);
        chk("rst_nof",   32'(norm_oflow), 32'd0);
        chk("rst_pulse", 32'(oflow_pulse), 32'd0);
        chk("rst_count", 32'(oflow_count), 32'd0);

        gain = 14'd64; oflow_mode = 2'b10; settle();
        run(16'd1000);
        chk("gain_dout",  32'(dout),        32'd1000);
        chk("gain_gof",   32'(gain_oflow),  32'd0);
        chk("gain_count", 32'(oflow_count), 32'd0);
        chk("gain_pulse", 32'(oflow_pulse), 32'd0);

        gain = 14'd8191; settle();
        run(16'd32767);
        chk("possat_dout",  32'(dout),        32'h7FFF);
        chk("possat_gof",   32'(gain_oflow),  32'd1);
        chk("possat_pulse", 32'(oflow_pulse), 32'd1);
        chk("possat_count", 32'(oflow_count), 32'd1);
        @(negedge clk);
        chk("pulse_one_cycle", 32'(oflow_pulse), 32'd0);

        oflow_mode = 2'b01; settle();
        run(16'd32767);
        chk("kill_dout",  32'(dout),        32'd0);
        chk("kill_count", 32'(oflow_count), 32'd2);

        oflow_mode = 2'b10; settle();
        run(16'h8000);
        chk("negsat_dout",  32'(dout),        32'h8000);
        chk("negsat_count", 32'(oflow_count), 32'd3);

        oflow_mode = 2'b00; settle();
        run(16'h8000);
        chk("wrap_dout",  32'(dout),        32'h0200);
        chk("wrap_count", 32'(oflow_count), 32'd4);
        chk("wrap_nof",   32'(norm_oflow),  32'd0);

        gain = 14'd64; use_diode = 1'b1; lut_val = 18'd32768; oflow_mode = 2'b10; settle();
        run(16'd1000);
        chk("diode_x1", 32'(dout), 32'd1000);
        lut_val = 18'd16384; settle();
        run(16'd1000);
        chk("diode_half",  32'(dout),        32'd500);
        chk("diode_count", 32'(oflow_count), 32'd4);

        lut_val = 18'd65536; settle();
        run(16'd20000);
        chk("norm_sat_dout",  32'(dout),        32'h7FFF);
        chk("norm_sat_nof",   32'(norm_oflow),  32'd1);
        chk("norm_sat_count", 32'(oflow_count), 32'd5);

        use_diode = 1'b0; gain = 14'd8191; settle();
        send(16'd32767);
        repeat (3) @(negedge clk);
        clr_oflow = 1'b1;
        @(negedge clk);
        clr_oflow = 1'b0;
        chk("arb_valid", 32'(dout_valid),  32'd1);
        chk("arb_gof",   32'(gain_oflow),  32'd1);
        chk("arb_nof",   32'(norm_oflow),  32'd0);
        chk("arb_count", 32'(oflow_count), 32'd1);

        @(negedge clk);
        clr_oflow = 1'b1;
        @(negedge clk);
        clr_oflow = 1'b0;
        chk("clr_gof",   32'(gain_oflow),  32'd0);
        chk("clr_count", 32'(oflow_count), 32'd0);

        @(negedge clk);
        din = 16'd32767; din_valid = 1'b1;
        repeat (20) @(negedge clk);
        din_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("cnt4_hold",    32'(sat_oflow_count), 32'd15);
        chk("cnt16_twenty", 32'(oflow_count),     32'd20);
        chk("cnt4_gof",     32'(sat_gain_oflow),  32'd1);
        chk("cnt4_nof",     32'(sat_norm_oflow),  32'd0);
        chk("cnt4_pulse",   32'(sat_oflow_pulse), 32'd0);
        chk("cnt4_valid",   32'(sat_dout_valid),  32'd0);
        chk("cnt4_dout",    32'(sat_dout),        32'h7FFF);

        gain = 14'd64; settle();
        @(negedge clk);
        din = 16'd111; din_valid = 1'b1;
        repeat (3) @(negedge clk);
        din_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("flush_count", 32'(oflow_count), 32'd0);
        chk("flush_gof",   32'(gain_oflow),  32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("flush_no_valid", 32'(dout_valid), 32'd0);
        end

        settle();
        for (int t = 0; t < 13; t++) begin
            @(negedge clk);
            if (t >= 5) begin
                chk("bubble_valid", 32'(dout_valid), 32'(pat[t-5]));
                if (pat[t-5]) begin
                    chk("bubble_dout", 32'(dout), 32'(100 + t - 5));
                end
            end
            if (t < 8) begin
                din       = 16'(100 + t);
                din_valid = pat[t];
            end else begin
                din_valid = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_norm_mult_pipe
`default_nettype wire
